// File: rtl/keypad_if.sv
// Lock-panel keypad bundle: raw switch levels in, conditioned event pulses and entered code out.
// The master side is the frontend; the slave side is the panel/controller pair around it.
interface keypad_if #(
  parameter int CODE_LEN = 4
);
  localparam int CNT_W = $clog2(CODE_LEN + 1);

  logic [3:0]            btn_raw;
  logic                  enter_raw;
  logic                  clear_raw;
  logic [3:0]            btn_pulse;
  logic                  enter_pulse;
  logic                  clear_pulse;
  logic                  invalid_pulse;
  logic [2*CODE_LEN-1:0] code;
  logic [CNT_W-1:0]      digit_count;
  logic                  code_full;

  modport master (
    input  btn_raw, enter_raw, clear_raw,
    output btn_pulse, enter_pulse, clear_pulse, invalid_pulse,
    output code, digit_count, code_full
  );

  modport slave (
    output btn_raw, enter_raw, clear_raw,
    input  btn_pulse, enter_pulse, clear_pulse, invalid_pulse,
    input  code, digit_count, code_full
  );
endinterface

// File: rtl/keypad_frontend.sv
// Synchronizes, debounces and classifies the lock-panel switches into one-cycle event pulses,
// and accumulates accepted digits (2 bits each, newest in the low bits) into the entered code.
module keypad_frontend #(
  parameter int DEBOUNCE = 4,
  parameter int CODE_LEN = 4
) (
  input  logic     clk,
  input  logic     reset,
  keypad_if.master kp
);
  localparam int CNT_W = $clog2(CODE_LEN + 1);
  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam int CW    = 2 * CODE_LEN;

  logic [5:0]      raw_in;
  logic [5:0]      sync_p0, sync_p1;
  logic [5:0]      stable_p2, prev_p3;
  logic [DB_W-1:0] db_cnt_p2 [6];
  logic [5:0]      rise;
  logic            one_hot, accept;
  logic [1:0]      dig;

  logic [3:0]       btn_p4;
  logic             enter_p4, clear_p4, inv_p4;
  logic [CW-1:0]    code_p4, code_base, dig_ext;
  logic [CNT_W-1:0] cnt_p4, cnt_base;

  assign raw_in = {kp.clear_raw, kp.enter_raw, kp.btn_raw};

  // Stage p0/p1: two-flop synchronizer per input bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2/p3: per-bit debounce counter and stable level, plus last stable level for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_p2 <= '0;
      prev_p3   <= '0;
      for (int i = 0; i < 6; i++) db_cnt_p2[i] <= '0;
    end else begin
      prev_p3 <= stable_p2;
      for (int i = 0; i < 6; i++) begin
        if (sync_p1[i] == stable_p2[i]) begin
          db_cnt_p2[i] <= '0;
        end else if (db_cnt_p2[i] == DB_W'(DEBOUNCE - 1)) begin
          db_cnt_p2[i] <= '0;
          stable_p2[i] <= sync_p1[i];
        end else begin
          db_cnt_p2[i] <= db_cnt_p2[i] + 1'b1;
        end
      end
    end
  end

  assign rise = stable_p2 & ~prev_p3;

  // A press is accepted only if it is the sole rising input and nothing else is being held
  always_comb begin
    one_hot = (rise != '0) && ((rise & (rise - 6'd1)) == '0);
    accept  = one_hot && (stable_p2 == rise);
    dig     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (rise[i]) dig = 2'(i);
    end
  end

  // The cycle after an enter pulse wipes the code, so the consumer sees it alongside enter_pulse
  always_comb begin
    code_base     = enter_p4 ? '0 : code_p4;
    cnt_base      = enter_p4 ? '0 : cnt_p4;
    dig_ext       = '0;
    dig_ext[1:0]  = dig;
  end

  // Stage p4: registered event pulses and code register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_p4   <= '0;
      enter_p4 <= 1'b0;
      clear_p4 <= 1'b0;
      inv_p4   <= 1'b0;
      code_p4  <= '0;
      cnt_p4   <= '0;
    end else begin
      btn_p4   <= '0;
      enter_p4 <= 1'b0;
      clear_p4 <= 1'b0;
      inv_p4   <= 1'b0;
      code_p4  <= code_base;
      cnt_p4   <= cnt_base;
      if (rise != '0) begin
        if (!accept) begin
          inv_p4 <= 1'b1;
        end else if (rise[5]) begin
          clear_p4 <= 1'b1;
          code_p4  <= '0;
          cnt_p4   <= '0;
        end else if (rise[4]) begin
          enter_p4 <= 1'b1;
        end else if (cnt_base == CNT_W'(CODE_LEN)) begin
          inv_p4 <= 1'b1;
        end else begin
          btn_p4  <= rise[3:0];
          code_p4 <= (code_base << 2) | dig_ext;
          cnt_p4  <= cnt_base + 1'b1;
        end
      end
    end
  end

  assign kp.btn_pulse     = btn_p4;
  assign kp.enter_pulse   = enter_p4;
  assign kp.clear_pulse   = clear_p4;
  assign kp.invalid_pulse = inv_p4;
  assign kp.code          = code_p4;
  assign kp.digit_count   = cnt_p4;
  assign kp.code_full     = (cnt_p4 == CNT_W'(CODE_LEN));
endmodule

// File: tb/tb_keypad_frontend.sv
// Bench for keypad_frontend: directed scenarios plus random switch activity, every cycle
// compared against a window-based debounce/classification reference model.
`timescale 1ns/1ps
module tb_keypad_frontend;
  localparam int DEBOUNCE = 4;
  localparam int CODE_LEN = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  keypad_if #(.CODE_LEN(CODE_LEN)) kp ();
  keypad_frontend #(.DEBOUNCE(DEBOUNCE), .CODE_LEN(CODE_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  logic [5:0] raw = '0;
  assign kp.btn_raw   = raw[3:0];
  assign kp.enter_raw = raw[4];
  assign kp.clear_raw = raw[5];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: raw sample history, stable/previous levels, list of held digits
  logic [5:0] m_hist[$];
  logic [5:0] m_stable, m_prev;
  logic [1:0] m_code[$];
  logic       m_enter;
  logic [3:0] e_btn;
  logic       e_ent, e_clr, e_inv;

  int n_btn, n_ent, n_clr, n_inv;
  logic [7:0] code_at_enter, code_at_clear;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*CODE_LEN-1:0] m_pack();
    logic [2*CODE_LEN-1:0] p = '0;
    foreach (m_code[j]) p = (p << 2) | (2*CODE_LEN)'(m_code[j]);
    return p;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    repeat (DEBOUNCE + 1) m_hist.push_back(6'd0);
    m_stable = '0; m_prev = '0; m_enter = 1'b0;
    m_code.delete();
    e_btn = '0; e_ent = 1'b0; e_clr = 1'b0; e_inv = 1'b0;
  endtask

  // One clock edge of the model; m_hist[0] holds the raw sample of the previous edge
  task automatic model_edge();
    logic [5:0] r, st_new;
    logic       all_diff;
    int         idx;
    r = m_stable & ~m_prev;
    if (m_enter) m_code.delete();
    e_btn = '0; e_ent = 1'b0; e_clr = 1'b0; e_inv = 1'b0;
    if (r != 0) begin
      if ($countones(r) == 1 && m_stable == r) begin
        if (r[5]) begin
          e_clr = 1'b1;
          m_code.delete();
        end else if (r[4]) begin
          e_ent = 1'b1;
        end else if (m_code.size() < CODE_LEN) begin
          idx = 0;
          for (int i = 0; i < 4; i++) if (r[i]) idx = i;
          e_btn = r[3:0];
          m_code.push_back(2'(idx));
        end else begin
          e_inv = 1'b1;
        end
      end else begin
        e_inv = 1'b1;
      end
    end
    m_enter = e_ent;
    st_new = m_stable;
    for (int b = 0; b < 6; b++) begin
      all_diff = 1'b1;
      for (int k = 1; k <= DEBOUNCE; k++) if (m_hist[k][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) st_new[b] = ~m_stable[b];
    end
    m_prev   = m_stable;
    m_stable = st_new;
    m_hist.push_front(raw);
    void'(m_hist.pop_back());
  endtask

  task automatic tick();
    logic [6:0] pulses;
    @(posedge clk);
    if (reset) model_edge();
    #1;
    pulses = {kp.btn_pulse, kp.enter_pulse, kp.clear_pulse, kp.invalid_pulse};
    chk("pulses", 32'(pulses), 32'({e_btn, e_ent, e_clr, e_inv}));
    chk("code", 32'(kp.code), 32'(m_pack()));
    chk("digit_count", 32'(kp.digit_count), 32'(m_code.size()));
    chk("code_full", 32'(kp.code_full), 32'(m_code.size() == CODE_LEN));
    chk("one_event", 32'($countones({|kp.btn_pulse, kp.enter_pulse, kp.clear_pulse, kp.invalid_pulse}) <= 1), 32'd1);
    if (kp.btn_pulse != 0) n_btn++;
    if (kp.enter_pulse) begin n_ent++; code_at_enter = kp.code; end
    if (kp.clear_pulse) begin n_clr++; code_at_clear = kp.code; end
    if (kp.invalid_pulse) n_inv++;
  endtask

  task automatic hold(input logic [5:0] v, input int n);
    raw = v;
    repeat (n) tick();
  endtask

  task automatic press(input int b);
    hold(6'(1 << b), 8);
    hold(6'd0, 8);
  endtask

  task automatic clr_tally();
    n_btn = 0; n_ent = 0; n_clr = 0; n_inv = 0;
    code_at_enter = 8'hxx; code_at_clear = 8'hxx;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int sel;
    logic [5:0] v;
    model_reset();
    clr_tally();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_code", 32'(kp.code), 32'h0);
    chk("reset_count", 32'(kp.digit_count), 32'h0);
    chk("reset_full", 32'(kp.code_full), 32'h0);
    chk("reset_pulses", 32'({kp.btn_pulse, kp.enter_pulse, kp.clear_pulse, kp.invalid_pulse}), 32'h0);

    // Held digit 2: pulse after edge 6, no repeat while held
    @(negedge clk);
    reset = 1'b1;
    raw = 6'b000100;
    repeat (6) tick();
    chk("lat_no_early", 32'(n_btn), 32'd0);
    tick();
    chk("lat_pulse", 32'(kp.btn_pulse), 32'b0100);
    chk("lat_code", 32'(kp.code), 32'h02);
    chk("lat_count", 32'(kp.digit_count), 32'd1);
    hold(6'b000100, 20);
    hold(6'd0, 10);
    chk("held_once", 32'(n_btn), 32'd1);

    // Fill the code, overflow, then enter
    do_reset(); clr_tally();
    press(1); press(3); press(0); press(2);
    chk("full_code", 32'(kp.code), 32'h72);
    chk("full_flag", 32'(kp.code_full), 32'd1);
    clr_tally();
    press(1);
    chk("over_inv", 32'(n_inv), 32'd1);
    chk("over_btn", 32'(n_btn), 32'd0);
    chk("over_code", 32'(kp.code), 32'h72);
    clr_tally();
    press(4);
    chk("enter_cnt", 32'(n_ent), 32'd1);
    chk("enter_code", 32'(code_at_enter), 32'h72);
    chk("enter_clr_code", 32'(kp.code), 32'h0);
    chk("enter_clr_cnt", 32'(kp.digit_count), 32'd0);

    // Glitch and bounced press
    do_reset(); clr_tally();
    hold(6'd1, 3);
    hold(6'd0, 12);
    chk("glitch_none", 32'(n_btn + n_inv + n_ent + n_clr), 32'd0);
    hold(6'd1, 2); hold(6'd0, 1); hold(6'd1, 2); hold(6'd0, 1); hold(6'd1, 10);
    hold(6'd0, 1); hold(6'd1, 1); hold(6'd0, 12);
    chk("bounce_once", 32'(n_btn), 32'd1);
    chk("bounce_count", 32'(kp.digit_count), 32'd1);

    // Simultaneous rises, and a press while another is held
    do_reset(); clr_tally();
    hold(6'b010001, 10);
    hold(6'd0, 12);
    chk("simul_inv", 32'(n_inv), 32'd1);
    chk("simul_other", 32'(n_btn + n_ent), 32'd0);
    clr_tally();
    hold(6'b000010, 10);
    hold(6'b000110, 10);
    hold(6'd0, 12);
    chk("heldpress_btn", 32'(n_btn), 32'd1);
    chk("heldpress_inv", 32'(n_inv), 32'd1);

    // Clear wipes the code on the pulse edge
    do_reset(); clr_tally();
    press(2); press(1);
    press(5);
    chk("clear_cnt", 32'(n_clr), 32'd1);
    chk("clear_code", 32'(code_at_clear), 32'h0);
    press(3);
    chk("after_clear", 32'(kp.code), 32'h03);

    // Reset mid-entry with a button held through release
    do_reset(); clr_tally();
    press(2); press(1);
    chk("pre_reset_code", 32'(kp.code), 32'h09);
    hold(6'b001000, 3);
    @(posedge clk);
    #3 reset = 1'b0;
    model_reset();
    #1;
    chk("async_code", 32'(kp.code), 32'h0);
    chk("async_count", 32'(kp.digit_count), 32'h0);
    chk("async_pulses", 32'({kp.btn_pulse, kp.enter_pulse, kp.clear_pulse, kp.invalid_pulse}), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clr_tally();
    repeat (6) tick();
    chk("rst_no_early", 32'(n_btn), 32'd0);
    tick();
    chk("rst_pulse", 32'(kp.btn_pulse), 32'b1000);
    chk("rst_code", 32'(kp.code), 32'h03);
    hold(6'd0, 12);

    // Random switch activity against the model
    do_reset();
    for (int it = 0; it < 200; it++) begin
      sel = $urandom_range(0, 99);
      if (sel < 45)      v = 6'd0;
      else if (sel < 85) v = 6'(1 << $urandom_range(0, 5));
      else               v = 6'($urandom_range(0, 63));
      hold(v, $urandom_range(1, 12));
    end
    hold(6'd0, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
